input_cmd_scheduler: RTL and testbench
======================================

Name: input_cmd_scheduler

Overview:
- Sits between the raw BTN inputs and the player and game FSM.
- Debounces left/right/jump and queues in-game commands in a small FIFO.
- Issues at most one command per frame to the player, rate-limited, and never drops ordering.
- Replaces the per-cycle edge detection at the top level; start requests bypass the queue.

Parameters:
- DEPTH, 4: command FIFO entries; power of two, 2..16.
- DEBOUNCE_CYCLES, 400000: clock cycles an input level must be stable before it is accepted (10 ms at 40 MHz).
- CMD_GAP_FRAMES, 2: frame_done pulses that must elapse after an issue before the next issue; 0 means issue back-to-back frames.

Ports:
- clock  in  1  40 MHz pixel clock.
- reset  in  1  asynchronous, active-high reset.
- btn_left  in  1  raw BTN[1] level.
- btn_right  in  1  raw BTN[2] level.
- btn_jump  in  1  raw BTN[3] level.
- frame_done  in  1  one-cycle pulse per frame.
- game_active  in  1  from the game FSM.
- is_jumping  in  1  from player; jump in progress.
- move_left_pulse  out  1  one-cycle command to player.
- move_right_pulse  out  1  one-cycle command to player.
- jump_pulse  out  1  one-cycle command to player.
- start_pulse  out  1  one-cycle start request to the game FSM.
- queue_count  out  $clog2(DEPTH+1)  current FIFO occupancy.
- overflow  out  1  sticky; a command was dropped.

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM in IDLE, debounced levels 0, pending flags 0, gap counter 0.
- Debounce, per button:
  - 2-flop synchroniser feeding a counter.
  - The counter clears whenever the synced level differs from the debounced level.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the level still differing, the debounced level takes the synced value.
  - A debounced 0->1 transition sets that button's pending flag in the same cycle.
- Start path:
  - When game_active=0, a jump pending flag produces start_pulse=1 on the next cycle and clears the flag.
  - Left/right pending flags are cleared and not queued.
- Enqueue (game_active=1):
  - At most one push per cycle, in fixed priority left > right > jump.
  - Unserved pending flags persist and are pushed on later cycles.
  - Codes are cmd_t: LEFT=0, RIGHT=1, JUMP=2.
  - FIFO full: the pending flag is cleared, the command is dropped, and overflow is set.
- overflow clears only on reset or on a game_active 0->1 transition.
- Push and pop in the same cycle are both honoured; queue_count is unchanged.
- Dispatch FSM states: IDLE, ISSUE, GAP.
  - IDLE: on frame_done with the FIFO non-empty and game_active=1:
    - Head is JUMP and is_jumping=1: head is retained (head-of-line block), stay in IDLE.
    - Otherwise: pop the head and go to ISSUE.
  - ISSUE (one cycle):
    - Assert the pulse matching the popped code; the pulse appears the cycle after frame_done.
    - Go to GAP, loading the gap counter with CMD_GAP_FRAMES; go to IDLE instead if CMD_GAP_FRAMES=0.
  - GAP: decrement on each frame_done; when the counter hits 0, return to IDLE. The next issue needs a later frame_done.
- Game end: a game_active 1->0 transition flushes the FIFO, clears pending flags and the gap counter, and forces IDLE in the same cycle. No pulse is issued in that cycle.
- Output pulses are mutually exclusive and never wider than one cycle.
- Latency:
  - Debounced edge to FIFO entry: 1 cycle when uncontended.
  - frame_done to pulse: 1 cycle.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full is queue_count==DEPTH; empty is queue_count==0.

Optional Feature:
- Macro: CMD_CANCEL_EN.
- Defined: a LEFT push while the FIFO tail (the most recent un-popped entry) is RIGHT, or a RIGHT push while the tail is LEFT, removes the tail instead of enqueueing.
  - queue_count decrements and overflow is unaffected.
  - Cancellation never touches an entry being popped in the same cycle; in that case the new command is pushed normally.
- Undefined: all commands are enqueued as described above.

Decomposition:
- Package rail_rush_pkg holds:
  - typedef enum logic [1:0] cmd_t {CMD_LEFT, CMD_RIGHT, CMD_JUMP}.
  - typedef enum sched_state_t {S_IDLE, S_ISSUE, S_GAP}.
- One sub-module, btn_debounce (synchroniser + counter + level + rise pulse, parameter DEBOUNCE_CYCLES), instantiated three times.
- The FIFO is inline.

Test Plan:
- All tests use DEBOUNCE_CYCLES=4, DEPTH=4, CMD_GAP_FRAMES=1.
- Bounce: btn_left toggles every 2 cycles for 20 cycles, then holds 1 -> exactly one LEFT enqueued; queue_count=1.
- Start: game_active=0, btn_jump held -> start_pulse high for exactly 1 cycle, 6 cycles after press; queue_count stays 0.
- Ordering and gap: queue LEFT, RIGHT, JUMP, then 6 frame_done -> pulses left@frame1, right@frame3, jump@frame5, each 1 cycle after its frame_done.
- Jump block: head JUMP with is_jumping=1 for 3 frames -> no pulse; jump_pulse on the first frame_done after is_jumping falls.
- Overflow: push 5 commands with no frame_done -> queue_count=4, overflow=1; overflow clears on game_active 0->1.
- Cancel and flush:
  - With CMD_CANCEL_EN: LEFT then RIGHT -> queue_count=0.
  - Drop game_active with 3 queued -> queue_count=0 the next cycle and no pulses.

Source files
------------

// File: rtl/rail_rush_pkg.sv
// Shared types for the Rail Rush input path: queued command codes and dispatch states.
package rail_rush_pkg;

   typedef enum logic [1:0] {
      CMD_LEFT  = 2'd0,
      CMD_RIGHT = 2'd1,
      CMD_JUMP  = 2'd2
   } cmd_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_GAP
   } sched_state_t;

   // True when two commands are a LEFT/RIGHT pair that cancel each other out.
   function automatic logic cmds_oppose(input cmd_t a, input cmd_t b);
      return ((a == CMD_LEFT) && (b == CMD_RIGHT)) || ((a == CMD_RIGHT) && (b == CMD_LEFT));
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter for one push button.
// Emits a single-cycle rise pulse when the accepted level goes 0 -> 1.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 400000
) (
   input  logic clock,
   input  logic reset,
   input  logic btn,
   output logic rise
);
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic             sync0;
   logic             sync1;
   logic             level;
   logic [CNT_W-1:0] stable_cnt;
   logic             accept;

   assign accept = (sync1 != level) && (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
   assign rise   = accept && sync1;

   // The counter only runs while the synced input disagrees with the accepted level.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync0      <= 1'b0;
         sync1      <= 1'b0;
         level      <= 1'b0;
         stable_cnt <= '0;
      end else begin
         sync0 <= btn;
         sync1 <= sync0;
         if (sync1 == level) begin
            stable_cnt <= '0;
         end else if (accept) begin
            level      <= sync1;
            stable_cnt <= '0;
         end else begin
            stable_cnt <= stable_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/input_cmd_scheduler.sv
// Debounces the buttons, queues in-game commands and issues at most one per frame.
// Optional build macro CMD_CANCEL_EN: a LEFT/RIGHT push against an opposing tail removes it.
module input_cmd_scheduler
   import rail_rush_pkg::*;
#(
   parameter int DEPTH           = 4,
   parameter int DEBOUNCE_CYCLES = 400000,
   parameter int CMD_GAP_FRAMES  = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       btn_left,
   input  logic                       btn_right,
   input  logic                       btn_jump,
   input  logic                       frame_done,
   input  logic                       game_active,
   input  logic                       is_jumping,
   output logic                       move_left_pulse,
   output logic                       move_right_pulse,
   output logic                       jump_pulse,
   output logic                       start_pulse,
   output logic [$clog2(DEPTH+1)-1:0] queue_count,
   output logic                       overflow
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int GAP_W = (CMD_GAP_FRAMES > 0) ? $clog2(CMD_GAP_FRAMES + 1) : 1;

   logic rise_left, rise_right, rise_jump;
   logic pend_left, pend_right, pend_jump;
   logic clr_left, clr_right, clr_jump;
   logic game_active_q, game_start, game_end;
   logic start_next, push_req, push_en, cancel, drop, pop, full, empty;
   cmd_t push_code, head_cmd, issue_code;
   cmd_t fifo_mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [GAP_W-1:0] gap_cnt;
   logic gap_load, gap_dec;
   sched_state_t state, next_state;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left  (.clock(clock), .reset(reset), .btn(btn_left),  .rise(rise_left));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (.clock(clock), .reset(reset), .btn(btn_right), .rise(rise_right));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_jump  (.clock(clock), .reset(reset), .btn(btn_jump),  .rise(rise_jump));

   assign game_start = game_active && !game_active_q;
   assign game_end   = !game_active && game_active_q;
   assign full       = (queue_count == CNT_W'(DEPTH));
   assign empty      = (queue_count == '0);
   assign head_cmd   = fifo_mem[rd_ptr];

   always_comb begin
      push_req   = 1'b0;
      push_code  = CMD_LEFT;
      clr_left   = 1'b0;
      clr_right  = 1'b0;
      clr_jump   = 1'b0;
      start_next = 1'b0;
      if (game_end) begin
         clr_left  = 1'b1;
         clr_right = 1'b1;
         clr_jump  = 1'b1;
      end else if (!game_active) begin
         clr_left   = pend_left;
         clr_right  = pend_right;
         clr_jump   = pend_jump;
         start_next = pend_jump;
      end else if (pend_left) begin
         push_req = 1'b1;
         clr_left = 1'b1;
      end else if (pend_right) begin
         push_req  = 1'b1;
         push_code = CMD_RIGHT;
         clr_right = 1'b1;
      end else if (pend_jump) begin
         push_req  = 1'b1;
         push_code = CMD_JUMP;
         clr_jump  = 1'b1;
      end
   end

`ifdef CMD_CANCEL_EN
   cmd_t tail_cmd;
   assign tail_cmd = fifo_mem[wr_ptr - PTR_W'(1)];
   // A tail that is leaving through the pop port this cycle is not eligible for cancellation.
   assign cancel   = push_req && !empty && !(pop && (queue_count == CNT_W'(1)))
                     && cmds_oppose(push_code, tail_cmd);
`else
   assign cancel   = 1'b0;
`endif
   assign push_en  = push_req && !cancel && (!full || pop);
   assign drop     = push_req && !cancel && full && !pop;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         game_active_q <= 1'b0;
         start_pulse   <= 1'b0;
         pend_left     <= 1'b0;
         pend_right    <= 1'b0;
         pend_jump     <= 1'b0;
         overflow      <= 1'b0;
      end else begin
         game_active_q <= game_active;
         start_pulse   <= start_next;
         pend_left     <= game_end ? 1'b0 : ((pend_left  && !clr_left)  || rise_left);
         pend_right    <= game_end ? 1'b0 : ((pend_right && !clr_right) || rise_right);
         pend_jump     <= game_end ? 1'b0 : ((pend_jump  && !clr_jump)  || rise_jump);
         if (drop) begin
            overflow <= 1'b1;
         end else if (game_start) begin
            overflow <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         queue_count <= '0;
      end else if (game_end) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         queue_count <= '0;
      end else begin
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push_en) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end else if (cancel) begin
            wr_ptr <= wr_ptr - PTR_W'(1);
         end
         queue_count <= queue_count + CNT_W'(push_en) - CNT_W'(pop) - CNT_W'(cancel);
      end
   end

   always_ff @(posedge clock) begin
      if (push_en) begin
         fifo_mem[wr_ptr] <= push_code;
      end
   end

   // A JUMP at the head waits while the player is mid-jump; nothing behind it may overtake.
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      gap_load   = 1'b0;
      gap_dec    = 1'b0;
      if (game_end) begin
         next_state = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (frame_done && game_active && !empty
                   && !((head_cmd == CMD_JUMP) && is_jumping)) begin
                  pop        = 1'b1;
                  next_state = S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (CMD_GAP_FRAMES == 0) begin
                  next_state = S_IDLE;
               end else begin
                  gap_load   = 1'b1;
                  next_state = S_GAP;
               end
            end
            S_GAP: begin
               if (frame_done) begin
                  gap_dec = 1'b1;
                  if (gap_cnt <= GAP_W'(1)) begin
                     next_state = S_IDLE;
                  end
               end
            end
            default: next_state = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         gap_cnt    <= '0;
         issue_code <= CMD_LEFT;
      end else begin
         state <= next_state;
         if (pop) begin
            issue_code <= head_cmd;
         end
         if (game_end) begin
            gap_cnt <= '0;
         end else if (gap_load) begin
            gap_cnt <= GAP_W'(CMD_GAP_FRAMES);
         end else if (gap_dec && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
         end
      end
   end

   assign move_left_pulse  = (state == S_ISSUE) && game_active && (issue_code == CMD_LEFT);
   assign move_right_pulse = (state == S_ISSUE) && game_active && (issue_code == CMD_RIGHT);
   assign jump_pulse       = (state == S_ISSUE) && game_active && (issue_code == CMD_JUMP);

endmodule

// File: tb/tb_input_cmd_scheduler.sv
// Directed, table-driven bench for input_cmd_scheduler (DEPTH=4, DEBOUNCE_CYCLES=4, CMD_GAP_FRAMES=1).
module tb_input_cmd_scheduler;
   import rail_rush_pkg::*;

   localparam int DEPTH = 4;
   localparam int DEB   = 4;
   localparam int GAP   = 1;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clock = 1'b0;
   logic          reset;
   logic          btn_left, btn_right, btn_jump;
   logic          frame_done, game_active, is_jumping;
   logic          move_left_pulse, move_right_pulse, jump_pulse, start_pulse;
   logic [CW-1:0] queue_count;
   logic          overflow;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic fd;
      logic jmp;
      logic l;
      logic r;
      logic j;
      int   cnt;
   } vec_t;

   vec_t order_vecs [18];
   vec_t block_vecs [8];
   cmd_t ord [3];

   input_cmd_scheduler #(
      .DEPTH(DEPTH),
      .DEBOUNCE_CYCLES(DEB),
      .CMD_GAP_FRAMES(GAP)
   ) dut (
      .clock(clock),
      .reset(reset),
      .btn_left(btn_left),
      .btn_right(btn_right),
      .btn_jump(btn_jump),
      .frame_done(frame_done),
      .game_active(game_active),
      .is_jumping(is_jumping),
      .move_left_pulse(move_left_pulse),
      .move_right_pulse(move_right_pulse),
      .jump_pulse(jump_pulse),
      .start_pulse(start_pulse),
      .queue_count(queue_count),
      .overflow(overflow)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic fd, input logic jmp);
      frame_done = fd;
      is_jumping = jmp;
      tick();
      frame_done = 1'b0;
   endtask

   task automatic runVector(input vec_t v, input string tag);
      applyStimulus(v.fd, v.jmp);
      checkOutput({tag, "_left"},  int'(move_left_pulse),  int'(v.l));
      checkOutput({tag, "_right"}, int'(move_right_pulse), int'(v.r));
      checkOutput({tag, "_jump"},  int'(jump_pulse),       int'(v.j));
      checkOutput({tag, "_count"}, int'(queue_count),      v.cnt);
   endtask

   task automatic doReset();
      reset       = 1'b1;
      btn_left    = 1'b0;
      btn_right   = 1'b0;
      btn_jump    = 1'b0;
      frame_done  = 1'b0;
      game_active = 1'b0;
      is_jumping  = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   // Clean press long enough to debounce, then a clean release that also settles.
   task automatic pressButton(input cmd_t c);
      case (c)
         CMD_LEFT:  btn_left  = 1'b1;
         CMD_RIGHT: btn_right = 1'b1;
         default:   btn_jump  = 1'b1;
      endcase
      repeat (10) tick();
      btn_left  = 1'b0;
      btn_right = 1'b0;
      btn_jump  = 1'b0;
      repeat (8) tick();
   endtask

   function automatic vec_t mkVec(input logic fd, input logic jmp, input logic l,
                                  input logic r, input logic j, input int cnt);
      vec_t v;
      v.fd  = fd;
      v.jmp = jmp;
      v.l   = l;
      v.r   = r;
      v.j   = j;
      v.cnt = cnt;
      return v;
   endfunction

   initial begin
`ifdef CMD_CANCEL_EN
      ord[0] = CMD_LEFT;
      ord[1] = CMD_JUMP;
      ord[2] = CMD_RIGHT;
`else
      ord[0] = CMD_LEFT;
      ord[1] = CMD_RIGHT;
      ord[2] = CMD_JUMP;
`endif
      // Six frames of three cycles each; pops land on frames 1, 3 and 5 with one gap frame between.
      for (int f = 0; f < 6; f++) begin
         order_vecs[3*f] = mkVec(1'b1, 1'b0,
                                 (f % 2 == 0) && (ord[f/2] == CMD_LEFT),
                                 (f % 2 == 0) && (ord[f/2] == CMD_RIGHT),
                                 (f % 2 == 0) && (ord[f/2] == CMD_JUMP),
                                 2 - f/2);
         order_vecs[3*f+1] = mkVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2 - f/2);
         order_vecs[3*f+2] = mkVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2 - f/2);
      end
      for (int f = 0; f < 3; f++) begin
         block_vecs[2*f]   = mkVec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
         block_vecs[2*f+1] = mkVec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
      end
      block_vecs[6] = mkVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      block_vecs[7] = mkVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);

      reset       = 1'b1;
      btn_left    = 1'b0;
      btn_right   = 1'b0;
      btn_jump    = 1'b0;
      frame_done  = 1'b0;
      game_active = 1'b0;
      is_jumping  = 1'b0;
      tick();
      tick();
      checkOutput("rst_count", int'(queue_count), 0);
      checkOutput("rst_overflow", int'(overflow), 0);
      checkOutput("rst_start", int'(start_pulse), 0);
      checkOutput("rst_left", int'(move_left_pulse), 0);
      checkOutput("rst_right", int'(move_right_pulse), 0);
      checkOutput("rst_jump", int'(jump_pulse), 0);
      reset = 1'b0;
      tick();

      $display("[TB] bounce");
      game_active = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         btn_left = 1'b1;
         tick();
         tick();
         btn_left = 1'b0;
         tick();
         tick();
      end
      checkOutput("bounce_count_during", int'(queue_count), 0);
      btn_left = 1'b1;
      repeat (12) tick();
      checkOutput("bounce_count_held", int'(queue_count), 1);
      btn_left = 1'b0;
      repeat (8) tick();
      checkOutput("bounce_count_released", int'(queue_count), 1);
      applyStimulus(1'b1, 1'b0);
      checkOutput("bounce_left_pulse", int'(move_left_pulse), 1);
      checkOutput("bounce_count_after_pop", int'(queue_count), 0);

      $display("[TB] start path");
      doReset();
      btn_jump = 1'b1;
      // The press is first sampled on edge 1; start_pulse follows six cycles later on edge 7.
      for (int k = 1; k <= 12; k++) begin
         tick();
         checkOutput($sformatf("start_cyc%0d", k), int'(start_pulse), (k == 7) ? 1 : 0);
      end
      checkOutput("start_count", int'(queue_count), 0);
      btn_jump = 1'b0;
      repeat (8) tick();
      pressButton(CMD_LEFT);
      checkOutput("start_left_not_queued", int'(queue_count), 0);

      $display("[TB] ordering and gap");
      doReset();
      game_active = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         pressButton(ord[i]);
         checkOutput($sformatf("order_fill%0d", i), int'(queue_count), i + 1);
      end
      for (int i = 0; i < 18; i++) begin
         runVector(order_vecs[i], $sformatf("order_v%0d", i));
      end

      $display("[TB] jump head-of-line block");
      pressButton(CMD_JUMP);
      checkOutput("block_fill", int'(queue_count), 1);
      for (int i = 0; i < 8; i++) begin
         runVector(block_vecs[i], $sformatf("block_v%0d", i));
      end

      $display("[TB] overflow");
      doReset();
      game_active = 1'b1;
      tick();
      pressButton(CMD_LEFT);
      pressButton(CMD_LEFT);
      pressButton(CMD_JUMP);
      pressButton(CMD_JUMP);
      checkOutput("ovf_count_full", int'(queue_count), 4);
      checkOutput("ovf_flag_before", int'(overflow), 0);
      pressButton(CMD_JUMP);
      checkOutput("ovf_count_after", int'(queue_count), 4);
      checkOutput("ovf_flag_set", int'(overflow), 1);
      game_active = 1'b0;
      tick();
      checkOutput("ovf_flush_count", int'(queue_count), 0);
      checkOutput("ovf_flag_sticky", int'(overflow), 1);
      game_active = 1'b1;
      tick();
      checkOutput("ovf_flag_cleared", int'(overflow), 0);

      $display("[TB] flush");
      doReset();
      game_active = 1'b1;
      tick();
      pressButton(CMD_LEFT);
      pressButton(CMD_JUMP);
      pressButton(CMD_JUMP);
      checkOutput("flush_fill", int'(queue_count), 3);
      game_active = 1'b0;
      tick();
      checkOutput("flush_count", int'(queue_count), 0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("flush_no_left", int'(move_left_pulse), 0);
      checkOutput("flush_no_jump", int'(jump_pulse), 0);
      game_active = 1'b1;
      tick();
      applyStimulus(1'b1, 1'b0);
      checkOutput("flush_empty_no_left", int'(move_left_pulse), 0);
      checkOutput("flush_empty_no_jump", int'(jump_pulse), 0);

      $display("[TB] left then right");
      doReset();
      game_active = 1'b1;
      tick();
      pressButton(CMD_LEFT);
      pressButton(CMD_RIGHT);
`ifdef CMD_CANCEL_EN
      checkOutput("cancel_count", int'(queue_count), 0);
`else
      checkOutput("cancel_count", int'(queue_count), 2);
`endif
      checkOutput("cancel_overflow", int'(overflow), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
